// File: rtl/relm_uart_io.sv
// relm_uart_io: 8N1 UART bridge between PE push/pop channels and txd/rxd.
// Ports: clk, reset_in (sync, active-high); push_d/push_retry (TX byte in);
//   pop_d/pop_q (RX byte out, [WD]=retry, [WD-1]=overrun); rxd in; txd out.
module relm_uart_io #(
  parameter int WD     = 32,
  parameter int CLKDIV = 434,
  parameter int WDIV   = 16
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic        rxd,
  output logic        txd
);

  localparam logic [WDIV-1:0] BIT_LAST  = WDIV'(CLKDIV - 1);
  localparam logic [WDIV-1:0] HALF_LAST = WDIV'(CLKDIV / 2 - 1);
  localparam logic [WDIV-1:0] ONE       = WDIV'(1);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [WDIV-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_byte_q, hold_byte_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [WDIV-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            rx_prev_q, rx_prev_d;
  logic            rx_full_q, rx_full_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            overrun_q, overrun_d;

  logic tx_load;
  logic rx_valid;
  logic unused_bits;

  assign unused_bits = ^{push_d[WD-1:8], pop_d[WD-1:0]};
  assign push_retry  = push_d[WD] & hold_full_q;
  assign txd         = txd_q;

  always_comb begin
    pop_q = '0;
    if (pop_d[WD]) begin
      if (rx_full_q)
        pop_q = {1'b0, overrun_q, {(WD-9){1'b0}}, rx_byte_q};
      else
        pop_q[WD] = 1'b1;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    tx_load     = 1'b0;
    if (push_d[WD] && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_byte_d = push_d[7:0];
    end
    unique case (tx_state_q)
      TX_IDLE: tx_load = hold_full_q;
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          // Pending byte starts straight out of the stop bit: no idle gap.
          tx_load    = hold_full_q;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // hold_full is set here, so no push can be accepted in this cycle.
    if (tx_load) begin
      tx_state_d  = TX_START;
      tx_cnt_d    = '0;
      tx_shift_d  = hold_byte_q;
      hold_full_d = 1'b0;
      txd_d       = 1'b0;
    end
  end

  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_full_d  = rx_full_q;
    rx_byte_d  = rx_byte_q;
    overrun_d  = overrun_q;
    rx_valid   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Half-bit check rejects glitches and aligns later samples mid-bit.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7)
            rx_state_d = RX_STOP;
          else
            rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid   = sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (pop_d[WD] && rx_full_q) begin
      rx_full_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (rx_valid) begin
      if (!rx_full_q || pop_d[WD]) begin
        rx_byte_d = rx_shift_q;
        rx_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_prev_q  <= rx_prev_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: doc/relm_uart_io.md
RELM_UART_IO -- requirements
Module: relm_uart_io

Interface
REQ-001 Parameter WD, default 32: PE data width; push and pop buses are WD+1 bits wide, with bit WD as the strobe or retry flag.
REQ-002 Parameter CLKDIV, default 434: clock cycles per UART bit; legal range 4..65535.
REQ-003 Parameter WDIV, default 16: width of the baud and bit-phase counters.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 push_d  input  WD+1  TX request from the PE push channel; [WD] strobe, [7:0] byte, [WD-1:8] ignored.
REQ-007 push_retry  output  1  combinational; high = push not accepted this cycle, PE retries.
REQ-008 pop_d  input  WD+1  RX request from the PE pop channel; [WD] strobe, [WD-1:0] ignored.
REQ-009 pop_q  output  WD+1  pop response: [WD] retry, [WD-1] overrun flag, [WD-2:8] zero, [7:0] byte.
REQ-010 rxd  input  1  asynchronous serial input; idle level is high.
REQ-011 txd  output  1  registered serial output; idle level is high.

Function
REQ-012 Frame format: 8N1, LSB first; each bit lasts exactly CLKDIV cycles.
REQ-013 TX holding register: one byte plus a full flag.
REQ-014 push_retry = push_d[WD] & hold_full.
REQ-015 A push with push_d[WD]=1 and hold_full=0 loads push_d[7:0] into the holding register and sets hold_full on the next edge.
REQ-016 TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
REQ-017 TX_IDLE with hold_full=1: move the byte into the shift register, clear hold_full, enter TX_START, drive txd=0 on the next edge.
REQ-018 In the same cycle as REQ-017, a new push is refused (push_retry=1); it is accepted one cycle later.
REQ-019 TX_START lasts CLKDIV cycles, then TX_DATA.
REQ-020 TX_DATA sends 8 bits, CLKDIV cycles each, then TX_STOP.
REQ-021 TX_STOP drives txd=1 for CLKDIV cycles, then TX_IDLE; if hold_full=1 the next start bit follows with no gap.
REQ-022 rxd passes through a 2-flop synchronizer before any use.
REQ-023 RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-024 RX_IDLE: a synchronized 1->0 transition enters RX_START.
REQ-025 RX_START: at CLKDIV/2 cycles (integer divide), sample rxd; if high (glitch), return to RX_IDLE; if low, enter RX_DATA.
REQ-026 RX_DATA: sample each data bit at its mid-bit, every CLKDIV cycles.
REQ-027 RX_STOP: sample once at mid-bit, then return to RX_IDLE.
REQ-028 Stop sample high: the byte is valid; stop sample low (framing error): the byte is discarded and no flag is set.
REQ-029 RX buffer: one byte plus a full flag.
REQ-030 Valid byte with buffer empty, or full but popped in the same cycle: store the byte and set full.
REQ-031 Valid byte with buffer full and no pop that cycle: discard the new byte, keep the old one, set sticky overrun.
REQ-032 pop_d[WD]=0: pop_q is all zero.
REQ-033 pop_d[WD]=1 with buffer empty: pop_q = {1'b1, WD{0}}; no state change.
REQ-034 pop_d[WD]=1 with buffer full: pop_q = {1'b0, overrun, zeros, byte}; full and overrun clear on the next edge unless REQ-030 refills the buffer in the same cycle.
REQ-035 pop_q and push_retry are combinational from registered state and the request strobes; read latency is zero cycles.

Reset
REQ-036 While reset_in=1, on each edge: both FSMs go idle, all counters clear, hold_full=0, RX buffer full=0, overrun=0, txd=1, synchronizer flops=1.
REQ-037 Reset mid-frame aborts the frame: txd=1 on the next edge, any partial RX byte is discarded.
REQ-038 During reset, push_retry follows REQ-014 using the cleared state and is 0 after the first reset edge; pop_q follows REQ-032..REQ-034.

Verification (CLKDIV=4)
REQ-039 Reset, push 0x55 -> txd low for 4 cycles from the cycle after the load, bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4; total frame 40 cycles.
REQ-040 Push 0x01, push 0x02 back-to-back -> second push gets retry=1 until holding frees; frames are contiguous, no idle gap.
REQ-041 Loop txd to rxd, send 0xA3, pop -> pop_q[WD]=1 before completion; after RX_STOP, pop_q = {0, 0, 0..., 0xA3}, next pop retries.
REQ-042 Two frames received without a pop -> pop returns the first byte with pop_q[WD-1]=1; a following pop retries.
REQ-043 rxd low pulse of 1 cycle, then high -> no byte stored; frame with stop bit low -> no byte stored, no overrun.
REQ-044 reset_in asserted mid-TX_DATA -> txd=1 next cycle, push_retry=0, pop returns retry.
